pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the pipeline. It produces the instruction-fetch address and chip enable for instruction memory, and adds three things the single-width counter did not have: a configurable reset vector and address width, branch and exception redirects, and a ready/valid fetch handshake. A branch arriving during a stall is buffered and applied once the stall releases.

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program counter with reset vector, branch and
//                exception redirects, buffered branch-under-stall and a
//                ready/valid fetch handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INSTR_BYTES  = 4,
    parameter int                    STOP_WIDTH   = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STOP_WIDTH-1:0] stop_all,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  exception_flag,
    input  logic [ADDR_WIDTH-1:0] exception_target,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] program_counter,
    output logic                  chip_enable,
    output logic                  fetch_valid,
    output logic                  redirect_pending,
    output logic                  misaligned_target
);

    localparam int OFFSET_BITS = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 0;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

    logic                  stall;
    logic                  unused_stop_bits;
    logic [ADDR_WIDTH-1:0] pending_target;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] target_next;
    logic                  pending_next;
    logic                  misaligned_next;

    // Only the fetch-stage stall bit matters here.
    assign stall            = stop_all[0];
    assign unused_stop_bits = ^stop_all;
    assign fetch_valid      = chip_enable & ~stall;

    function automatic logic low_bits_set(input logic [ADDR_WIDTH-1:0] t);
        return (t & ~ALIGN_MASK) != '0;
    endfunction

    always_comb begin
        pc_next         = program_counter;
        pending_next    = redirect_pending;
        target_next     = pending_target;
        misaligned_next = 1'b0;
        if (chip_enable) begin
            if (exception_flag) begin
                pc_next         = exception_target & ALIGN_MASK;
                pending_next    = 1'b0;
                misaligned_next = low_bits_set(exception_target);
            end else if (stall) begin
                if (branch_flag) begin
                    pending_next = 1'b1;
                    target_next  = branch_target;
                end
            end else if (branch_flag) begin
                pc_next         = branch_target & ALIGN_MASK;
                pending_next    = 1'b0;
                misaligned_next = low_bits_set(branch_target);
            end else if (redirect_pending) begin
                pc_next         = pending_target & ALIGN_MASK;
                pending_next    = 1'b0;
                misaligned_next = low_bits_set(pending_target);
            end else if (fetch_ready) begin
                // Natural wrap modulo 2^ADDR_WIDTH.
                pc_next = program_counter + PC_STEP;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            program_counter   <= RESET_VECTOR;
            chip_enable       <= 1'b0;
            redirect_pending  <= 1'b0;
            pending_target    <= '0;
            misaligned_target <= 1'b0;
        end else begin
            program_counter   <= pc_next;
            chip_enable       <= 1'b1;
            redirect_pending  <= pending_next;
            pending_target    <= target_next;
            misaligned_target <= misaligned_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Directed vector bench for pc_gen (32-bit, 16-bit wrap and
//                byte-step instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_gen;

    logic        clock;
    logic        reset;
    logic [5:0]  stop_all;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        exception_flag;
    logic [31:0] exception_target;
    logic        fetch_ready;

    logic [31:0] a_pc;
    logic        a_ce, a_valid, a_pend, a_mis;
    logic [15:0] b_pc;
    logic        b_ce, b_valid, b_pend, b_mis;
    logic [7:0]  c_pc;
    logic        c_ce, c_valid, c_pend, c_mis;

    int tests  = 0;
    int failed = 0;

    pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'hBFC00000), .INSTR_BYTES(4), .STOP_WIDTH(6)) u_a (
        .clock(clock), .reset(reset), .stop_all(stop_all),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .exception_flag(exception_flag), .exception_target(exception_target),
        .fetch_ready(fetch_ready), .program_counter(a_pc), .chip_enable(a_ce),
        .fetch_valid(a_valid), .redirect_pending(a_pend), .misaligned_target(a_mis));

    pc_gen #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0100), .INSTR_BYTES(4), .STOP_WIDTH(6)) u_b (
        .clock(clock), .reset(reset), .stop_all(stop_all),
        .branch_flag(branch_flag), .branch_target(branch_target[15:0]),
        .exception_flag(exception_flag), .exception_target(exception_target[15:0]),
        .fetch_ready(fetch_ready), .program_counter(b_pc), .chip_enable(b_ce),
        .fetch_valid(b_valid), .redirect_pending(b_pend), .misaligned_target(b_mis));

    pc_gen #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h10), .INSTR_BYTES(1), .STOP_WIDTH(6)) u_c (
        .clock(clock), .reset(reset), .stop_all(stop_all),
        .branch_flag(branch_flag), .branch_target(branch_target[7:0]),
        .exception_flag(exception_flag), .exception_target(exception_target[7:0]),
        .fetch_ready(fetch_ready), .program_counter(c_pc), .chip_enable(c_ce),
        .fetch_valid(c_valid), .redirect_pending(c_pend), .misaligned_target(c_mis));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        stop;
        logic        bf;
        logic [31:0] bt;
        logic        ef;
        logic [31:0] et;
        logic        rdy;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //               stop bf  bt            ef  et            rdy pc            ce   pend mis  valid
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hBFC00000,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hBFC00004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hBFC00008,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hBFC00008,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,32'h00001000, 1'b0,32'h0,        1'b1,32'hBFC00008,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hBFC00008,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00001000,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00001004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h00001004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h00001004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00001008,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b1,32'h00003000, 1'b0,32'h0,        1'b1,32'h00001008,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b1,32'h00000180, 1'b0,32'h00000180,1'b1,1'b0,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h00000180,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b1,32'h00002002, 1'b0,32'h0,        1'b1,32'h00002000,1'b1,1'b0,1'b1,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00002004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1,32'h00000183, 1'b1,32'h00000180,1'b1,1'b0,1'b1,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00000184,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b1,32'h00004006, 1'b0,32'h0,        1'b1,32'h00000184,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,32'h00005000, 1'b0,32'h0,        1'b1,32'h00000184,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h00006000, 1'b0,32'h0,        1'b1,32'h00006000,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00006004,1'b1,1'b0,1'b0,1'b1});
        vecs.push_back('{1'b1,1'b1,32'h00007001, 1'b0,32'h0,        1'b1,32'h00006004,1'b1,1'b1,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h00007000,1'b1,1'b0,1'b1,1'b1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h00007004,1'b1,1'b0,1'b0,1'b1});

        reset = 1'b0; stop_all = 6'b0; branch_flag = 1'b0; branch_target = '0;
        exception_flag = 1'b0; exception_target = '0; fetch_ready = 1'b1;
        tick();
        tick();
        chk("reset_pc",    a_pc,    32'hBFC00000);
        chk("reset_ce",    {31'b0, a_ce},    32'd0);
        chk("reset_pend",  {31'b0, a_pend},  32'd0);
        chk("reset_mis",   {31'b0, a_mis},   32'd0);
        chk("reset_valid", {31'b0, a_valid}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            // Upper stall bits toggle to show they are ignored.
            stop_all         = {5'b10110 ^ 5'(i), vecs[i].stop};
            branch_flag      = vecs[i].bf;
            branch_target    = vecs[i].bt;
            exception_flag   = vecs[i].ef;
            exception_target = vecs[i].et;
            fetch_ready      = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_pc", i),    a_pc,              vecs[i].pc);
            chk($sformatf("v%0d_ce", i),    {31'b0, a_ce},     {31'b0, vecs[i].ce});
            chk($sformatf("v%0d_pend", i),  {31'b0, a_pend},   {31'b0, vecs[i].pend});
            chk($sformatf("v%0d_mis", i),   {31'b0, a_mis},    {31'b0, vecs[i].mis});
            chk($sformatf("v%0d_valid", i), {31'b0, a_valid},  {31'b0, vecs[i].valid});
        end

        // Narrow-width wrap and byte-step instance.
        stop_all = 6'b0; exception_flag = 1'b0;
        branch_flag = 1'b1; branch_target = 32'h0000FFFE; fetch_ready = 1'b0;
        tick();
        chk("b_branch_pc", {16'b0, b_pc}, 32'h0000FFFC);
        chk("b_branch_mis", {31'b0, b_mis}, 32'd1);
        chk("c_branch_pc", {24'b0, c_pc}, 32'h000000FE);
        chk("c_branch_mis", {31'b0, c_mis}, 32'd0);
        branch_flag = 1'b0; fetch_ready = 1'b1;
        tick();
        chk("b_wrap_pc", {16'b0, b_pc}, 32'h00000000);
        chk("c_inc_pc", {24'b0, c_pc}, 32'h000000FF);
        chk("a_inc_pc", a_pc, 32'h00010000);
        tick();
        chk("b_after_wrap_pc", {16'b0, b_pc}, 32'h00000004);
        chk("c_wrap_pc", {24'b0, c_pc}, 32'h00000000);

        // Mid-stream asynchronous reset discards a pending branch.
        stop_all = 6'b000001; branch_flag = 1'b1; branch_target = 32'h00008000; fetch_ready = 1'b0;
        tick();
        chk("pre_reset_pend", {31'b0, a_pend}, 32'd1);
        branch_flag = 1'b0; stop_all = 6'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async_a_pc", a_pc, 32'hBFC00000);
        chk("async_a_ce", {31'b0, a_ce}, 32'd0);
        chk("async_a_pend", {31'b0, a_pend}, 32'd0);
        chk("async_b_pc", {16'b0, b_pc}, 32'h00000100);
        chk("async_b_ce", {31'b0, b_ce}, 32'd0);
        chk("async_c_pc", {24'b0, c_pc}, 32'h00000010);
        tick();
        reset = 1'b1;
        tick();
        chk("rerelease_ce", {31'b0, a_ce}, 32'd1);
        chk("rerelease_pc", a_pc, 32'hBFC00000);
        tick();
        chk("lost_pending_pc", a_pc, 32'hBFC00000);
        chk("lost_pending_pend", {31'b0, a_pend}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
